mux_nto1_seq: RTL
=================

MUX_NTO1_SEQ -- requirements
Module: mux_nto1_seq

Interface
REQ-001 SHALL have parameter NCH, default 4: number of input channels, 2..16.
REQ-002 SHALL have parameter W, default 8: data width per channel, 1..64.
REQ-003 SHALL define derived constant SW = clog2(NCH): select/channel-index width.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous reset, active-high.
REQ-007 in_data  input  NCH*W  channel k occupies bits [k*W+W-1 : k*W].
REQ-008 in_valid  input  NCH  per-channel data-valid flags.
REQ-009 mode  input  1  0 = MANUAL (use sel), 1 = SCAN (round-robin over valid channels).
REQ-010 sel  input  SW  channel index in MANUAL mode; values >= NCH select nothing.
REQ-011 out_data  output  W  registered selected data.
REQ-012 out_ch  output  SW  index of the channel that produced out_data.
REQ-013 out_valid  output  1  out_data/out_ch hold a valid word.
REQ-014 out_ready  input  1  downstream accepts the word when out_valid && out_ready.
REQ-015 in_ack  output  NCH  one-hot, combinational; bit k high in the cycle channel k is captured.

Function
REQ-016 The output register SHALL be "free" when out_valid==0 or out_ready==1 in the current cycle.
REQ-017 A capture SHALL occur on a rising edge only when the register is free and a channel is granted.
REQ-018 A capture SHALL load out_data, out_ch and set out_valid=1; latency from granted input to out_valid is 1 cycle.
REQ-019 With out_valid==1 and out_ready==0, out_data, out_ch and out_valid SHALL hold unchanged and in_ack SHALL be 0.
REQ-020 A transfer with no new capture in the same cycle SHALL clear out_valid on the next edge.
REQ-021 A transfer and a capture in the same cycle SHALL be allowed: back-to-back throughput of 1 word/cycle.
REQ-022 In MANUAL mode, the grant SHALL be channel sel iff sel < NCH and in_valid[sel]==1; otherwise no grant.
REQ-023 In SCAN mode, the grant SHALL be the first channel with in_valid set, searching from (ptr+1) mod NCH upward with wrap-around.
REQ-024 ptr (SW bits) SHALL update to the granted index only on a capture in SCAN mode; it is otherwise held, including in MANUAL mode.
REQ-025 In SCAN mode with all in_valid bits high, successive captures SHALL visit channels 0,1,...,NCH-1,0,... in order, starting after ptr.
REQ-026 A mode change SHALL take effect in the same cycle; ptr is not reset by a mode change.
REQ-027 With no valid channel, no capture SHALL occur and in_ack SHALL be all-zero.
REQ-028 in_ack SHALL assert only for the granted channel and only when the capture actually occurs (free && grant).

Reset
REQ-029 rst high SHALL immediately force out_valid=0, out_data=0, out_ch=0 and ptr=NCH-1, so the first SCAN grant search starts at channel 0.
REQ-030 Reset asserted mid-transfer SHALL discard the held word; no capture occurs while rst is high, and in_ack=0 during reset.
REQ-031 After rst deasserts, the first capture SHALL be possible on the first rising edge.

Structure
REQ-032 Mode encodings (MODE_MANUAL=0, MODE_SCAN=1) SHALL reside in the shared package/header for the mux family.
REQ-033 The round-robin search SHALL be a combinational sub-module rr_pick with inputs req[NCH] and ptr[SW], and outputs gnt_valid and gnt_idx[SW].
REQ-034 The top level SHALL contain only the grant muxing, the output register, the ptr register and in_ack generation.

Verification
REQ-035 NCH=4, W=8, MANUAL, sel=2, in_valid=0100, data ch2=0xA5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_ch=2; in_ack=0100 in the capture cycle.
REQ-036 SCAN, in_valid=1111, data ch k=0x10+k, out_ready=1, after reset -> out_data sequence 0x10, 0x11, 0x12, 0x13, 0x10 on consecutive cycles.
REQ-037 SCAN, in_valid=1010, out_ready held 0 for 3 cycles -> out_data=ch1 held for 3 cycles, in_ack=0; ready=1 -> next word is ch3, then ch1.
REQ-038 MANUAL, sel=5 (SW=3, NCH=5) or in_valid[sel]=0 -> out_valid stays 0, in_ack=0000.
REQ-039 rst pulsed while out_valid=1 and out_ready=0 -> out_valid=0 asynchronously; first SCAN grant after release is the lowest valid channel.
REQ-040 Switch from SCAN (ptr=1) to MANUAL sel=3, then back to SCAN with in_valid=1111 -> MANUAL captures ch3 and ptr stays 1; next SCAN capture is ch2.

Source files
------------

// File: rtl/mux_nto1_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_nto1_seq_pkg
// Description : Shared definitions for the N-to-1 sequential mux family.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_nto1_seq_pkg;

  // Selection mode encodings driven on the mode input
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage : mux_nto1_seq_pkg
`default_nettype wire

// File: rtl/mux_nto1_seq_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Finds the first set request
//               starting at (ptr+1) mod NCH and wrapping upward.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NCH = 4,
  localparam int SW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  ptr,
  output logic           gnt_valid,
  output logic [SW-1:0]  gnt_idx
);

  // Rotate the requests so bit 0 is the channel after ptr, then take the
  // lowest set bit and map it back to an absolute channel index.
  always_comb begin
    int base;
    int c;
    logic [2*NCH-1:0] dbl;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    base      = int'(ptr) + 1;
    dbl       = {req, req} >> base;
    c         = 0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (dbl[j]) begin
        c = base + j;
        if (c >= NCH) c = c - NCH;
        if (c >= NCH) c = c - NCH;
        gnt_valid = 1'b1;
        gnt_idx   = SW'(c);
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mux_nto1_seq.sv
`default_nettype none
// ============================================================================
// Module      : mux_nto1_seq
// Description : N-to-1 registered mux with manual select or round-robin scan,
//               a valid/ready output register and a one-hot capture ack.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nto1_seq
  import mux_nto1_seq_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 8,
  localparam int SW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   in_valid,
  input  logic             mode,
  input  logic [SW-1:0]    sel,
  output logic [W-1:0]     out_data,
  output logic [SW-1:0]    out_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NCH-1:0]   in_ack
);

  localparam logic [SW-1:0] PTR_RESET = SW'(NCH - 1);

  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_ch_q,    out_ch_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  logic          rr_valid;
  logic [SW-1:0] rr_idx;
  logic          man_valid;
  logic          grant_valid;
  logic [SW-1:0] grant_idx;
  logic [W-1:0]  grant_data;
  logic          free;
  logic          capture;

  rr_pick #(
    .NCH (NCH)
  ) u_rr_pick (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // Manual grant: sel must name an existing channel that has valid data
  always_comb begin
    man_valid = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SW'(k) && in_valid[k]) man_valid = 1'b1;
    end
  end

  // Grant selection by mode, data mux, capture decision and one-hot ack
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    case (mode)
      MODE_MANUAL: begin
        grant_valid = man_valid;
        grant_idx   = sel;
      end
      MODE_SCAN: begin
        grant_valid = rr_valid;
        grant_idx   = rr_idx;
      end
      default: begin
        grant_valid = 1'b0;
        grant_idx   = '0;
      end
    endcase
    grant_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant_idx == SW'(k)) grant_data = in_data[k*W +: W];
    end
    free    = !out_valid_q || out_ready;
    capture = free && grant_valid && !rst;
    in_ack  = '0;
    for (int k = 0; k < NCH; k++) begin
      in_ack[k] = capture && (grant_idx == SW'(k));
    end
  end

  // Next-state for the output register and the scan pointer
  always_comb begin
    out_valid_d = capture || (out_valid_q && !out_ready);
    out_data_d  = capture ? grant_data : out_data_q;
    out_ch_d    = capture ? grant_idx  : out_ch_q;
    ptr_d       = (capture && mode == MODE_SCAN) ? grant_idx : ptr_q;
  end

  // Output register and pointer; reset parks ptr so scanning starts at ch 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= PTR_RESET;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule : mux_nto1_seq
`default_nettype wire
